spmv_row_sched: RTL and testbench
=================================

Name: spmv_row_sched

Overview:
- Sequences the SpMV row accumulator for a batch of rows.
- Takes one nnz count per row on an AXI-Stream length channel and gates the product stream from the multiplier into the accumulator.
- Marks the first product of each row so the accumulator loads instead of adds, waits out the accumulator pipeline, then hands a row-done token to the result writer.
- Replaces a free-running clear counter with explicit per-row sequencing and zero-length row support.

Parameters:
LEN_W, 32, width of the per-row nnz count
ROW_W, 32, width of the row counter / batch row count
ACC_LAT, 4, accumulator pipeline depth in cycles (valid range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  start batch pulse; sampled only in IDLE
cfg_nrows  in  ROW_W  number of rows in batch; latched on cfg_start
s_len_tvalid  in  1  AXIS length channel valid
s_len_tdata  in  LEN_W  nnz count of next row
s_len_tready  out  1  AXIS length channel ready
prod_valid  in  1  multiplier product valid
prod_ready  out  1  product accepted by accumulator path
acc_en  out  1  accumulator consumes product this cycle
acc_first  out  1  with acc_en: load, not add (first product of row)
row_done_valid  out  1  row result ready for writer
row_done_ready  in  1  writer accepts row token
row_done_idx  out  ROW_W  index of completed row
row_done_empty  out  1  row had nnz=0; writer stores 0.0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at batch completion

Behaviour:
- Reset (rst=1 at posedge), from any state including mid-row:
  - State goes to IDLE.
  - All outputs 0; row_done_idx=0.
  - Internal remaining count, flush counter and first flag cleared.
  - In-flight products are dropped; upstream must be reset alongside.
- IDLE:
  - Outputs deasserted.
  - On cfg_start, latch nrows and set row_idx=0.
  - nrows==0 -> DONE; else -> LOAD.
- LOAD:
  - s_len_tready=1.
  - On handshake with tdata==0: row_done_empty_r=1 -> EMIT.
  - On handshake with tdata!=0: remaining=tdata, first=1, empty_r=0 -> ACCUM.
- ACCUM:
  - prod_ready=1; acc_en = prod_valid (combinational); acc_first = acc_en & first.
  - On each accepted product: first<=0, remaining<=remaining-1.
  - Accepted product with remaining==1 -> FLUSH, flush counter=ACC_LAT-1.
  - s_len_tready=0 throughout.
- FLUSH:
  - prod_ready=0; counter decrements each cycle.
  - Counter==0 -> EMIT. FLUSH therefore lasts exactly ACC_LAT cycles.
  - Latency from last acc_en to row_done_valid = ACC_LAT+1 cycles.
- EMIT:
  - row_done_valid=1; row_done_idx=row_idx; row_done_empty=empty_r.
  - All three are held stable until row_done_ready (AXIS rules; valid never drops without a handshake).
  - On handshake: row_idx==nrows-1 -> DONE; else row_idx++ -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- Width and arithmetic rules:
  - remaining is LEN_W bits; the maximum count 2^LEN_W-1 must be supported with no wrap.
  - row_idx compare uses nrows-1, computed at ROW_W with nrows!=0 guaranteed by the IDLE branch.
- Handshake and signal rules:
  - prod_ready and s_len_tready are never high in the same cycle.
  - cfg_start is ignored while busy.
  - s_len_tvalid and prod_valid outside their own states are ignored; no state change results.

Test Plan:
- nrows=3, lens {2,1,3}, prod_valid held high, row_done_ready=1:
  - acc_en high for 2, 1 and 3 cycles; acc_first high on the 1st of each run.
  - Row tokens idx 0,1,2 with empty=0.
  - Each token ACC_LAT+1=5 cycles after the row's last acc_en.
  - done pulses once; busy falls the next cycle.
- nrows=2, lens {0,2}:
  - Token idx0 with empty=1 and no acc_en.
  - Then 2 products, token idx1 with empty=0, done.
- Backpressure: row_done_ready=0 for 10 cycles in EMIT:
  - valid, idx and empty stay stable; s_len_tready=0 and prod_ready=0 throughout.
  - Handshake on the 11th cycle advances to LOAD.
- Gapped products, len=4, prod_valid pattern 1,0,0,1,1,0,1:
  - acc_en exactly on the valid cycles; acc_first only on the first.
  - FLUSH entered after the 4th product.
- rst asserted in ACCUM with remaining=2:
  - Next cycle: IDLE, all outputs 0.
  - New cfg_start with nrows=1, len=1 completes normally with idx 0.
- cfg_nrows=0:
  - done pulses 2 cycles after cfg_start.
  - No s_len_tready, no row_done_valid.
  - A cfg_start pulse during a batch has no effect.

Source files
------------

// File: rtl/spmv_row_sched.sv
// Row sequencer for the SpMV accumulator: takes one nnz count per row, gates products
// into the accumulator, waits out its pipeline and issues one row-done token per row.
module spmv_row_sched #(
    parameter int LEN_W   = 32,
    parameter int ROW_W   = 32,
    parameter int ACC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [ROW_W-1:0] cfg_nrows,
    input  logic             s_len_tvalid,
    input  logic [LEN_W-1:0] s_len_tdata,
    output logic             s_len_tready,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic             acc_en,
    output logic             acc_first,
    output logic             row_done_valid,
    input  logic             row_done_ready,
    output logic [ROW_W-1:0] row_done_idx,
    output logic             row_done_empty,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_FLUSH,
        S_EMIT,
        S_DONE
    } state_t;

    // The flush counter only ever needs to hold ACC_LAT-1, at most 14.
    localparam logic [3:0] FLUSH_INIT = 4'(ACC_LAT - 1);

    state_t           state_reg, state_next;
    logic [ROW_W-1:0] nrows_reg, nrows_next;
    logic [ROW_W-1:0] row_idx_reg, row_idx_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [3:0]       flush_cnt_reg, flush_cnt_next;
    logic             first_reg, first_next;
    logic             empty_reg, empty_next;
    logic [ROW_W-1:0] last_row;

    // Safe from underflow: a zero-row batch never leaves IDLE for LOAD.
    assign last_row = nrows_reg - ROW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            nrows_reg     <= '0;
            row_idx_reg   <= '0;
            remaining_reg <= '0;
            flush_cnt_reg <= '0;
            first_reg     <= 1'b0;
            empty_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            nrows_reg     <= nrows_next;
            row_idx_reg   <= row_idx_next;
            remaining_reg <= remaining_next;
            flush_cnt_reg <= flush_cnt_next;
            first_reg     <= first_next;
            empty_reg     <= empty_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        nrows_next     = nrows_reg;
        row_idx_next   = row_idx_reg;
        remaining_next = remaining_reg;
        flush_cnt_next = flush_cnt_reg;
        first_next     = first_reg;
        empty_next     = empty_reg;
        s_len_tready   = 1'b0;
        prod_ready     = 1'b0;
        acc_en         = 1'b0;
        acc_first      = 1'b0;
        row_done_valid = 1'b0;
        row_done_idx   = '0;
        row_done_empty = 1'b0;
        busy           = (state_reg != S_IDLE);
        done           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cfg_start) begin
                    nrows_next   = cfg_nrows;
                    row_idx_next = '0;
                    state_next   = (cfg_nrows == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                s_len_tready = 1'b1;
                if (s_len_tvalid) begin
                    if (s_len_tdata == '0) begin
                        empty_next = 1'b1;
                        state_next = S_EMIT;
                    end else begin
                        remaining_next = s_len_tdata;
                        first_next     = 1'b1;
                        empty_next     = 1'b0;
                        state_next     = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                prod_ready = 1'b1;
                acc_en     = prod_valid;
                acc_first  = prod_valid & first_reg;
                if (prod_valid) begin
                    first_next     = 1'b0;
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        flush_cnt_next = FLUSH_INIT;
                        state_next     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Counts ACC_LAT-1 down to 0, so the accumulator gets exactly ACC_LAT cycles.
                if (flush_cnt_reg == 4'd0) begin
                    state_next = S_EMIT;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                end
            end
            S_EMIT: begin
                row_done_valid = 1'b1;
                row_done_idx   = row_idx_reg;
                row_done_empty = empty_reg;
                if (row_done_ready) begin
                    if (row_idx_reg == last_row) begin
                        state_next = S_DONE;
                    end else begin
                        row_idx_next = row_idx_reg + ROW_W'(1);
                        state_next   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spmv_row_sched.sv
// Directed and randomized batches for spmv_row_sched, checked against an event-level
// reference: per-row product counts, first-product marks, token order, flush latency.
module tb_spmv_row_sched;
    localparam int LEN_W   = 32;
    localparam int ROW_W   = 32;
    localparam int ACC_LAT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_start = 1'b0;
    logic [ROW_W-1:0] cfg_nrows = '0;
    logic             s_len_tvalid = 1'b0;
    logic [LEN_W-1:0] s_len_tdata = '0;
    logic             s_len_tready;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic             acc_en;
    logic             acc_first;
    logic             row_done_valid;
    logic             row_done_ready = 1'b0;
    logic [ROW_W-1:0] row_done_idx;
    logic             row_done_empty;
    logic             busy;
    logic             done;

    spmv_row_sched #(.LEN_W(LEN_W), .ROW_W(ROW_W), .ACC_LAT(ACC_LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_nrows(cfg_nrows),
        .s_len_tvalid(s_len_tvalid), .s_len_tdata(s_len_tdata), .s_len_tready(s_len_tready),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_en(acc_en), .acc_first(acc_first),
        .row_done_valid(row_done_valid), .row_done_ready(row_done_ready),
        .row_done_idx(row_done_idx), .row_done_empty(row_done_empty),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: what the batch should look like at the transaction level
    int  lens[$];
    int  pv_pat[$];
    int  nrows_m, len_ptr, cur_row, cur_len, cur_cnt, last_acc, done_cnt, done_cyc, start_cyc;
    bit  tok_open, in_batch, mid_start;
    int  tok_age, rdy_hold;
    int  pv_pct, lv_pct, rdy_pct;
    longint tok_idx, tok_empty;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        len_ptr = 0; cur_row = 0; cur_len = 0; cur_cnt = 0; last_acc = -1000;
        done_cnt = 0; done_cyc = -1; tok_open = 0; tok_age = 0; in_batch = 0;
    endtask

    // One clock cycle: drive, let outputs settle, check, then advance past the edge.
    task automatic tick();
        if (pv_pat.size() > 0 && cur_cnt < cur_len) prod_valid = (pv_pat.pop_front() != 0);
        else prod_valid = ($urandom_range(0, 99) < pv_pct);
        s_len_tvalid = (len_ptr < lens.size()) && ($urandom_range(0, 99) < lv_pct);
        s_len_tdata  = s_len_tvalid ? LEN_W'(lens[len_ptr]) : LEN_W'($urandom);
        row_done_ready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        if (row_done_valid && tok_age < rdy_hold) row_done_ready = 1'b0;
        #1;
        chk("ready_excl", longint'(prod_ready & s_len_tready), 0);
        chk("acc_en_gate", longint'(acc_en), longint'(prod_valid & prod_ready));
        if (in_batch) chk("busy", longint'(busy), 1);
        if (row_done_valid) begin
            chk("emit_len_rdy", longint'(s_len_tready), 0);
            chk("emit_prod_rdy", longint'(prod_ready), 0);
        end
        if (acc_en) begin
            chk("acc_first", longint'(acc_first), longint'(cur_cnt == 0));
            chk("prod_in_row", longint'(cur_cnt < cur_len), 1);
            cur_cnt++;
            last_acc = cyc;
        end else begin
            chk("first_wo_en", longint'(acc_first), 0);
        end
        if (s_len_tready) chk("len_needed", longint'(len_ptr < nrows_m), 1);
        if (s_len_tvalid && s_len_tready) begin
            chk("len_order", cur_row, len_ptr);
            cur_len = lens[len_ptr];
            len_ptr++;
            cur_cnt = 0;
        end
        if (row_done_valid) begin
            if (!tok_open) begin
                tok_open = 1; tok_age = 0;
                chk("tok_idx", longint'(row_done_idx), cur_row);
                chk("tok_empty", longint'(row_done_empty), longint'(cur_len == 0));
                chk("tok_prods", cur_cnt, cur_len);
                chk("tok_row_loaded", len_ptr, cur_row + 1);
                if (cur_len != 0) chk("flush_lat", cyc - last_acc, ACC_LAT + 1);
                tok_idx = longint'(row_done_idx);
                tok_empty = longint'(row_done_empty);
            end else begin
                chk("hold_idx", longint'(row_done_idx), tok_idx);
                chk("hold_empty", longint'(row_done_empty), tok_empty);
            end
            if (row_done_ready) begin
                tok_open = 0; cur_row++; cur_len = 0; cur_cnt = 0;
            end else begin
                tok_age++;
            end
        end else begin
            chk("tok_dropped", longint'(tok_open), 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_rows", cur_row, nrows_m);
            chk("done_lens", len_ptr, nrows_m);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_batch(input int n, input int abort_at);
        nrows_m = n;
        model_clear();
        cfg_start = 1'b1;
        cfg_nrows = ROW_W'(n);
        start_cyc = cyc;
        tick();
        cfg_start = 1'b0;
        in_batch = 1;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            if (mid_start) begin
                cfg_start = ($urandom_range(0, 7) == 0);
                cfg_nrows = ROW_W'($urandom_range(0, 3));
            end
            tick();
            if (abort_at >= 0 && cur_len != 0 && cur_cnt == abort_at) return;
        end
        cfg_start = 1'b0;
        in_batch = 0;
        chk("done_once", done_cnt, 1);
        if (n == 0) chk("zero_done_lat", longint'(done_cyc - start_cyc <= 2), 1);
        chk("busy_after", longint'(busy), 0);
        chk("done_pulse", longint'(done), 0);
        $display("batch nrows=%0d rows_tokened=%0d cycle=%0d", n, cur_row, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 1'b0;
        s_len_tvalid = 1'b0;
        row_done_ready = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_len_rdy", longint'(s_len_tready), 0);
        chk("rst_prod_rdy", longint'(prod_ready), 0);
        chk("rst_acc_en", longint'(acc_en), 0);
        chk("rst_acc_first", longint'(acc_first), 0);
        chk("rst_tok_valid", longint'(row_done_valid), 0);
        chk("rst_tok_idx", longint'(row_done_idx), 0);
        chk("rst_tok_empty", longint'(row_done_empty), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        $display("reset applied cycle=%0d", cyc);
    endtask

    initial begin
        pv_pct = 100; lv_pct = 100; rdy_pct = 100; rdy_hold = 0; mid_start = 0;
        nrows_m = 0;
        @(posedge clk);
        #1;
        do_reset();

        lens = '{2, 1, 3};
        run_batch(3, -1);

        lens = '{0, 2};
        run_batch(2, -1);

        // Writer stalls each token for 10 cycles, accepts on the 11th
        rdy_hold = 10;
        lens = '{1, 0, 2};
        run_batch(3, -1);
        rdy_hold = 0;

        pv_pct = 0;
        pv_pat = '{1, 0, 0, 1, 1, 0, 1};
        lens = '{4};
        run_batch(1, -1);
        pv_pat.delete();
        pv_pct = 100;

        // Reset mid-row with two products still outstanding
        lens = '{5};
        run_batch(1, 3);
        prod_valid = 1'b1;
        do_reset();
        lens = '{1};
        run_batch(1, -1);

        lens.delete();
        run_batch(0, -1);

        mid_start = 1;
        for (int b = 0; b < 20; b++) begin
            int n;
            n = $urandom_range(1, 6);
            lens.delete();
            for (int r = 0; r < n; r++) lens.push_back($urandom_range(0, 5));
            pv_pct  = $urandom_range(30, 100);
            lv_pct  = $urandom_range(30, 100);
            rdy_pct = $urandom_range(30, 100);
            run_batch(n, -1);
        end
        mid_start = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
